vga_timing_out: RTL and testbench

Parametrised VGA timing generator and TinyVGA PMOD output stage. Produces pixel coordinates and strobes for the demo's pixel logic, then registers its colour reply together with generated sync into the packed 8-bit PMOD pin order. Includes a 1-bit audio output path with an optional sigma-delta DAC. It sits between the demo core and the chip's top-level pins, replacing hard-wired 640x480 timing and pin packing.

---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/vga_timing_out_if.sv | 15 +
 rtl/pdm_dac.sv | 24 ++
 rtl/vga_timing_out.sv | 88 ++++++++
 tb/tb_vga_timing_out.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing, TinyVGA PMOD pin map and pin-pack helper.
package vga_timing_pkg;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int PIN_HSYNC = 7;
   localparam int PIN_VSYNC = 3;
   localparam int PIN_R1    = 0;
   localparam int PIN_G1    = 1;
   localparam int PIN_B1    = 2;
   localparam int PIN_R0    = 4;
   localparam int PIN_G0    = 5;
   localparam int PIN_B0    = 6;

   function automatic logic [7:0] pack_pins(logic hs, logic vs, logic [1:0] r, logic [1:0] g, logic [1:0] b);
      logic [7:0] p;
      p = '0;
      p[PIN_HSYNC] = hs;
      p[PIN_VSYNC] = vs;
      p[PIN_R0] = r[0];
      p[PIN_R1] = r[1];
      p[PIN_G0] = g[0];
      p[PIN_G1] = g[1];
      p[PIN_B0] = b[0];
      p[PIN_B1] = b[1];
      return p;
   endfunction
endpackage

// File: rtl/vga_timing_out_if.sv
// vga_timing_out_if: pixel tick, colour reply, coordinates/strobes and PMOD/audio pins.
interface vga_timing_out_if #(parameter int CBITS = 2, parameter int AUDIO_BITS = 8);
   logic                  pix_en;
   logic [CBITS-1:0]      r_in, g_in, b_in;
   logic [AUDIO_BITS-1:0] audio_in;
   logic [10:0]           hpos;
   logic [9:0]            vpos;
   logic                  de, line_start, frame_start;
   logic [7:0]            uo_out;
   logic                  audio_out;
   modport master(input pix_en, r_in, g_in, b_in, audio_in,
                  output hpos, vpos, de, line_start, frame_start, uo_out, audio_out);
   modport slave(output pix_en, r_in, g_in, b_in, audio_in,
                 input hpos, vpos, de, line_start, frame_start, uo_out, audio_out);
endinterface

// File: rtl/pdm_dac.sv
// pdm_dac: first-order sigma-delta DAC; the accumulator carry is the 1-bit stream.
module pdm_dac #(parameter int AUDIO_BITS = 8) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [AUDIO_BITS-1:0] audio_in,
   output logic                  audio_out
);
   logic [AUDIO_BITS-1:0] acc_q, acc_d;
   logic                  out_q, out_d;

   always_comb {out_d, acc_d} = {1'b0, acc_q} + {1'b0, audio_in};

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         out_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         out_q <= out_d;
      end
   end

   assign audio_out = out_q;
endmodule

// File: rtl/vga_timing_out.sv
// vga_timing_out: parametrised VGA timing generator with registered TinyVGA PMOD pins.
// Define VGA_AUDIO_PDM_EN to build the sigma-delta audio DAC; otherwise audio_out is 0.
module vga_timing_out import vga_timing_pkg::*; #(
   parameter int H_ACTIVE   = DEF_H_ACTIVE,
   parameter int H_FP       = DEF_H_FP,
   parameter int H_SYNC     = DEF_H_SYNC,
   parameter int H_BP       = DEF_H_BP,
   parameter int V_ACTIVE   = DEF_V_ACTIVE,
   parameter int V_FP       = DEF_V_FP,
   parameter int V_SYNC     = DEF_V_SYNC,
   parameter int V_BP       = DEF_V_BP,
   parameter bit HSYNC_POL  = 1'b0,
   parameter bit VSYNC_POL  = 1'b0,
   parameter int CBITS      = 2,
   parameter int AUDIO_BITS = 8
) (
   input logic clk,
   input logic rst,
   vga_timing_out_if.master bus
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_bad_total
      $error("vga_timing_out: H_TOTAL must be <= 2048 and V_TOTAL <= 1024");
   end
   if (CBITS != 1 && CBITS != 2) begin : g_bad_cbits
      $error("vga_timing_out: CBITS must be 1 or 2");
   end

   logic [10:0] hpos_q, hpos_d;
   logic [9:0]  vpos_q, vpos_d;
   logic [7:0]  uo_q, uo_d;
   logic [1:0]  r_w, g_w, b_w;
   logic        h_wrap, de, hs, vs;

   // A single colour bit drives both pin bits of its channel.
   if (CBITS == 1) begin : g_c1
      assign r_w = {2{bus.r_in[0]}};
      assign g_w = {2{bus.g_in[0]}};
      assign b_w = {2{bus.b_in[0]}};
   end else begin : g_c2
      assign r_w = bus.r_in;
      assign g_w = bus.g_in;
      assign b_w = bus.b_in;
   end

   always_comb begin
      h_wrap = int'(hpos_q) == H_TOTAL - 1;
      de     = int'(hpos_q) < H_ACTIVE && int'(vpos_q) < V_ACTIVE;
      hs     = int'(hpos_q) >= H_ACTIVE + H_FP && int'(hpos_q) < H_ACTIVE + H_FP + H_SYNC;
      vs     = int'(vpos_q) >= V_ACTIVE + V_FP && int'(vpos_q) < V_ACTIVE + V_FP + V_SYNC;
      hpos_d = bus.pix_en ? (h_wrap ? '0 : hpos_q + 11'd1) : hpos_q;
      vpos_d = bus.pix_en && h_wrap ? (int'(vpos_q) == V_TOTAL - 1 ? '0 : vpos_q + 10'd1) : vpos_q;
      uo_d   = bus.pix_en ? pack_pins(hs ~^ HSYNC_POL, vs ~^ VSYNC_POL,
                                      de ? r_w : 2'b00, de ? g_w : 2'b00, de ? b_w : 2'b00) : uo_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hpos_q <= '0;
         vpos_q <= '0;
         uo_q   <= pack_pins(~HSYNC_POL, ~VSYNC_POL, 2'b00, 2'b00, 2'b00);
      end else begin
         hpos_q <= hpos_d;
         vpos_q <= vpos_d;
         uo_q   <= uo_d;
      end
   end

   assign bus.hpos        = hpos_q;
   assign bus.vpos        = vpos_q;
   assign bus.de          = de;
   assign bus.line_start  = bus.pix_en && hpos_q == '0;
   assign bus.frame_start = bus.pix_en && hpos_q == '0 && vpos_q == '0;
   assign bus.uo_out      = uo_q;

`ifdef VGA_AUDIO_PDM_EN
   pdm_dac #(.AUDIO_BITS(AUDIO_BITS)) u_dac (
      .clk(clk),
      .rst(rst),
      .audio_in(bus.audio_in),
      .audio_out(bus.audio_out)
   );
`else
   assign bus.audio_out = 1'b0;
`endif
endmodule

// File: tb/tb_vga_timing_out.sv
// tb_vga_timing_out: small-timing (15x8) bench with vector table, reference model and random stimulus.
module tb_vga_timing_out;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   vga_timing_out_if #(.CBITS(2), .AUDIO_BITS(8)) b0 ();
   vga_timing_out_if #(.CBITS(1), .AUDIO_BITS(8)) b1 ();

   vga_timing_out #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CBITS(2), .AUDIO_BITS(8))
      d0 (.clk(clk), .rst(rst), .bus(b0));

   vga_timing_out #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CBITS(1), .AUDIO_BITS(8))
      d1 (.clk(clk), .rst(rst), .bus(b1));

   typedef struct {
      logic        pe;
      logic [1:0]  r, g, b;
      logic [7:0]  uo;
      logic [10:0] hp;
   } vec_t;
   vec_t vec [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference pins from the timing rules of the 15x8 test geometry, active-low syncs.
   function automatic logic [7:0] ref_pins(int h, int v, logic [1:0] r, logic [1:0] g, logic [1:0] b);
      logic act, hs, vs;
      act = h < 8 && v < 4;
      hs  = h >= 10 && h < 13;
      vs  = v >= 5 && v < 7;
      return {~hs, act & b[0], act & g[0], act & r[0], ~vs, act & b[1], act & g[1], act & r[1]};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      b0.pix_en = 1'b1;
      b1.pix_en = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      b0.pix_en = 1'b0;
      b1.pix_en = 1'b0;
   endtask

   initial begin
      int n, h, v, hlow, vlow, on, off, hfirst, vfirst, fs0, fs1, ls0, ls1, ones;
      logic [7:0] exp_uo;
      logic rs, pe;
      logic [1:0] rr, gg, bb;
      b0.pix_en = 1'b0; b0.r_in = '0; b0.g_in = '0; b0.b_in = '0; b0.audio_in = '0;
      b1.pix_en = 1'b0; b1.r_in = '0; b1.g_in = '0; b1.b_in = '0; b1.audio_in = '0;
      vec[0] = '{1'b1, 2'd3, 2'd3, 2'd3, 8'hFF, 11'd1};
      vec[1] = '{1'b0, 2'd0, 2'd0, 2'd0, 8'hFF, 11'd1};
      vec[2] = '{1'b1, 2'd1, 2'd2, 2'd0, 8'h9A, 11'd2};
      vec[3] = '{1'b1, 2'd2, 2'd1, 2'd3, 8'hED, 11'd3};
      vec[4] = '{1'b0, 2'd3, 2'd3, 2'd3, 8'hED, 11'd3};
      vec[5] = '{1'b1, 2'd0, 2'd0, 2'd0, 8'h88, 11'd4};

      do_reset();
      check("rst_uo", b0.uo_out, 8'h88);
      check("rst_hpos", b0.hpos, 0);
      check("rst_vpos", b0.vpos, 0);
      check("rst_audio", b0.audio_out, 0);
      b0.pix_en = 1'b1;
      @(posedge clk); #1;
      check("first_tick_hpos", b0.hpos, 1);

      do_reset();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         b0.pix_en = vec[i].pe; b0.r_in = vec[i].r; b0.g_in = vec[i].g; b0.b_in = vec[i].b;
         @(posedge clk); #1;
         check($sformatf("vec%0d_uo", i), b0.uo_out, vec[i].uo);
         check($sformatf("vec%0d_hpos", i), b0.hpos, vec[i].hp);
      end

      do_reset();
      @(negedge clk);
      b1.pix_en = 1'b1; b1.r_in = 1'b1; b1.g_in = 1'b0; b1.b_in = 1'b1;
      @(posedge clk); #1;
      check("cbits1_uo", b1.uo_out, 8'hDD);
      @(negedge clk);
      b1.pix_en = 1'b0;

      // One full frame of continuous ticks with all-ones colour.
      do_reset();
      b0.pix_en = 1'b1; b0.r_in = 2'd3; b0.g_in = 2'd3; b0.b_in = 2'd3;
      hlow = 0; vlow = 0; on = 0; off = 0; hfirst = -1; vfirst = -1;
      for (int i = 0; i < 120; i++) begin
         @(posedge clk); #1;
         if (!b0.uo_out[7]) begin hlow++; if (hfirst < 0) hfirst = i; end
         if (!b0.uo_out[3]) begin vlow++; if (vfirst < 0) vfirst = i; end
         if ({b0.uo_out[6:4], b0.uo_out[2:0]} == 6'h3F) on++;
         if ({b0.uo_out[6:4], b0.uo_out[2:0]} == 6'h00) off++;
      end
      check("hsync_low_clks", hlow, 24);
      check("hsync_first", hfirst, 10);
      check("vsync_low_clks", vlow, 30);
      check("vsync_first", vfirst, 75);
      check("rgb_on_clks", on, 32);
      check("rgb_off_clks", off, 88);

      // Tick every third clock; outputs must hold between ticks.
      do_reset();
      n = 0; exp_uo = 8'h88; fs0 = -1; fs1 = -1; ls0 = -1; ls1 = -1;
      for (int c = 0; c < 1200; c++) begin
         @(negedge clk);
         b0.pix_en = (c % 3 == 0);
         #1;
         if (b0.frame_start) begin if (fs0 < 0) fs0 = c; else if (fs1 < 0) fs1 = c; end
         if (b0.line_start) begin if (ls0 < 0) ls0 = c; else if (ls1 < 0) ls1 = c; end
         @(posedge clk);
         if (b0.pix_en) begin exp_uo = ref_pins(n % 15, (n / 15) % 8, 2'd3, 2'd3, 2'd3); n++; end
         #1;
         if (c < 60) check("slow_uo", b0.uo_out, exp_uo);
      end
      check("frame_period", fs1 < 0 ? -1 : fs1 - fs0, 360);
      check("line_period", ls1 < 0 ? -1 : ls1 - ls0, 45);

      // Random ticks, colours and occasional mid-frame resets against the model.
      do_reset();
      n = 0; exp_uo = 8'h88;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         check("rnd_uo", b0.uo_out, exp_uo);
         pe = ($urandom % 3) != 0;
         rs = ($urandom % 256) == 0;
         rr = 2'($urandom); gg = 2'($urandom); bb = 2'($urandom);
         rst = rs; b0.pix_en = pe; b0.r_in = rr; b0.g_in = gg; b0.b_in = bb;
         #1;
         h = n % 15; v = (n / 15) % 8;
         check("rnd_hpos", b0.hpos, h);
         check("rnd_vpos", b0.vpos, v);
         check("rnd_de", b0.de, h < 8 && v < 4);
         check("rnd_line_start", b0.line_start, pe && h == 0);
         check("rnd_frame_start", b0.frame_start, pe && h == 0 && v == 0);
         if (rs) begin n = 0; exp_uo = 8'h88; end
         else if (pe) begin exp_uo = ref_pins(h, v, rr, gg, bb); n++; end
      end
      @(negedge clk);
      rst = 1'b0;

`ifdef VGA_AUDIO_PDM_EN
      for (int k = 0; k < 3; k++) begin
         b0.audio_in = k == 0 ? 8'd64 : (k == 1 ? 8'd0 : 8'd255);
         do_reset();
         ones = 0;
         for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
            ones += int'(b0.audio_out);
         end
         check($sformatf("pdm_ones_%0d", b0.audio_in), ones, b0.audio_in);
      end
      b0.audio_in = 8'd64;
      repeat (77) @(posedge clk);
      do_reset();
      check("pdm_rst_out", b0.audio_out, 0);
      ones = 0;
      for (int i = 0; i < 256; i++) begin
         @(posedge clk); #1;
         ones += int'(b0.audio_out);
      end
      check("pdm_after_rst", ones, 64);
`else
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         b0.audio_in = 8'($urandom);
         @(posedge clk); #1;
         check("audio_off", b0.audio_out, 0);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
